if_fetch_stage: RTL and testbench
=================================

// Module: if_fetch_stage
// PURPOSE
//  - Instruction-fetch stage of the 5-stage pipeline: holds the PC, computes PC+4, selects the next PC, and registers the fetched word into the IF/ID pipeline register.
//  - Sits directly upstream of ID; its next-PC select feeds a 32-bit 2:1 mux (mux2to1_32).
//  - Takes the redirect (branch/jump) and stall/flush controls from the hazard unit in ID.
// PARAMETERS
//  - RESET_PC   32'h0000_0000   PC value loaded on reset
//  - NOP_INSTR  32'h0000_0000   instruction word inserted into IF/ID on a bubble
// PORTS
//  - clk            in   1   rising-edge clock, sole clock domain
//  - rst_n          in   1   synchronous reset, active-low
//  - stall          in   1   freeze PC and IF/ID (load-use hazard)
//  - redirect       in   1   taken branch/jump resolved in ID this cycle
//  - redirect_pc    in   32  target address; bits [1:0] ignored (treated as 00)
//  - imem_addr      out  32  current PC, drives instruction memory
//  - imem_rdata     in   32  instruction at imem_addr, combinational, same cycle
//  - if_id_pc4      out  32  registered PC+4 of the instruction in ID
//  - if_id_instr    out  32  registered instruction word for ID
//  - if_id_valid    out  1   1 = if_id_instr is a real instruction, 0 = bubble
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge):
//    - pc <= RESET_PC
//    - if_id_pc4 <= 0
//    - if_id_instr <= NOP_INSTR
//    - if_id_valid <= 0
//    - Reset overrides every other input; reset mid-stall or mid-redirect discards all state.
//  - Datapath:
//    - imem_addr = pc; pc4 = pc + 32'd4, modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000, no flag).
//    - next_pc = redirect ? {redirect_pc[31:2],2'b00} : pc4, built with mux2to1_32 (sel=redirect, a=target, b=pc4).
//  - Per-edge priority, applied when rst_n=1:
//    1. stall=1: pc and all IF/ID registers hold. redirect is ignored; ID holds it asserted until the stall drops.
//    2. redirect=1: pc <= target; if_id_instr <= NOP_INSTR; if_id_valid <= 0; if_id_pc4 <= pc4. The wrong-path fetch is squashed. There is no delay slot.
//    3. Otherwise: pc <= pc4; if_id_instr <= imem_rdata; if_id_pc4 <= pc4; if_id_valid <= 1.
//  - Latency:
//    - One cycle from a fetch at PC to the instruction appearing at if_id_*.
//    - Redirect penalty is exactly one bubble.
//  - First valid instruction (RESET_PC) appears in IF/ID on the first edge after rst_n rises.
//  - Back-to-back redirects each load their own target and each insert one bubble.
// CONFIGURATION
//  - Macro FETCH_PERF_CNT_EN adds outputs stall_cnt[31:0] and flush_cnt[31:0].
//    - Each resets to 0.
//    - stall_cnt increments on each edge with stall=1.
//    - flush_cnt increments on each edge where a redirect is taken (redirect=1 && stall=0).
//    - Both counters saturate at 32'hFFFF_FFFF.
//  - Without the macro, the counter ports and logic are absent; all other behaviour is identical.
// STRUCTURE
//  - Shared package/include cpu_defs:
//    - `define XLEN 32
//    - PC increment constant 4
//    - NOP encoding
//    - RESET_PC default
//  - One sub-module: mux2to1_32, instantiated for next-PC selection.
//  - Everything else is flat: PC register, adder, IF/ID register, optional counters.
// TESTING
//  1. Reset/sequential fetch: hold rst_n=0 for 2 cycles, then release.
//     - imem_addr = 0x0, 0x4, 0x8, ...
//     - if_id_pc4 lags by one cycle (0x4, 0x8, ...)
//     - if_id_valid = 0 on the first edge after reset, then 1.
//  2. Redirect: at pc=0x10, pulse redirect=1 for one cycle with redirect_pc=0x103.
//     - Next cycle: imem_addr = 0x100, if_id_valid = 0, if_id_instr = NOP.
//     - Following cycle: the instruction from 0x100 is in ID with if_id_pc4 = 0x104.
//  3. Stall: assert stall for 3 cycles at pc=0x20.
//     - imem_addr stays 0x20; if_id_* unchanged for 3 cycles.
//     - Fetch resumes at 0x24 after release.
//  4. Stall+redirect together: stall=1 and redirect=1 (target 0x200) for 2 cycles, then stall=0 with redirect still 1.
//     - PC holds during the stall.
//     - PC = 0x200 one edge after the stall drops, with one bubble.
//  5. Wrap/reset mid-operation:
//     - Preload pc=0xFFFF_FFFC via redirect; next pc = 0x0.
//     - Drop rst_n during a redirect cycle: pc = RESET_PC, if_id_valid = 0.
//  6. FETCH_PERF_CNT_EN build: 3 stall cycles and 2 redirects give stall_cnt = 3 and flush_cnt = 2.
//     - Without the macro, the bench compiles without the counter ports.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
//==============================================================================
// Module      : cpu_defs (package)
// Description : Shared CPU constants: XLEN, PC increment, NOP encoding, reset PC.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

`ifndef XLEN
`define XLEN 32
`endif

package cpu_defs;
  localparam logic [`XLEN-1:0] c_pc_incr   = `XLEN'd4;
  localparam logic [`XLEN-1:0] c_nop_instr = `XLEN'h0000_0000;
  localparam logic [`XLEN-1:0] c_reset_pc  = `XLEN'h0000_0000;
endpackage

`default_nettype wire

// File: rtl/mux2to1_32.sv
//==============================================================================
// Module      : mux2to1_32
// Description : 32-bit 2:1 multiplexer; y = sel ? a : b.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mux2to1_32 (
  input  logic              sel,
  input  logic [`XLEN-1:0]  a,
  input  logic [`XLEN-1:0]  b,
  output logic [`XLEN-1:0]  y
);
  assign y = sel ? a : b;
endmodule

`default_nettype wire

// File: rtl/if_fetch_stage.sv
//==============================================================================
// Module      : if_fetch_stage
// Description : IF stage - PC register, PC+4, next-PC select, IF/ID register.
//               Optional FETCH_PERF_CNT_EN adds stall_cnt/flush_cnt outputs.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module if_fetch_stage
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC  = c_reset_pc,
  parameter logic [31:0] NOP_INSTR = c_nop_instr
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_pc4,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  logic [31:0] r_pc;
  logic [31:0] r_if_id_pc4;
  logic [31:0] r_if_id_instr;
  logic        r_if_id_valid;
  logic [31:0] w_pc4;
  logic [31:0] w_target;
  logic [31:0] w_next_pc;

  assign w_pc4    = r_pc + c_pc_incr;
  assign w_target = {redirect_pc[31:2], 2'b00};

  mux2to1_32 u_next_pc_mux (
    .sel (redirect),
    .a   (w_target),
    .b   (w_pc4),
    .y   (w_next_pc)
  );

  // Stall wins over redirect; ID keeps redirect asserted until the stall drops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_if_id_pc4   <= 32'h0;
      r_if_id_instr <= NOP_INSTR;
      r_if_id_valid <= 1'b0;
    end else if (!stall) begin
      r_pc        <= w_next_pc;
      r_if_id_pc4 <= w_pc4;
      if (redirect) begin
        r_if_id_instr <= NOP_INSTR;
        r_if_id_valid <= 1'b0;
      end else begin
        r_if_id_instr <= imem_rdata;
        r_if_id_valid <= 1'b1;
      end
    end
  end

  assign imem_addr   = r_pc;
  assign if_id_pc4   = r_if_id_pc4;
  assign if_id_instr = r_if_id_instr;
  assign if_id_valid = r_if_id_valid;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= 32'h0;
      r_flush_cnt <= 32'h0;
    end else begin
      if (stall && (r_stall_cnt != 32'hFFFF_FFFF))
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (redirect && !stall && (r_flush_cnt != 32'hFFFF_FFFF))
        r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
//==============================================================================
// Module      : tb_if_fetch_stage
// Description : Directed self-checking bench for if_fetch_stage.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_if_fetch_stage;
  localparam logic [31:0] c_nop = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_pc4;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Instruction memory model: every word is a known function of its address.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  assign imem_rdata = mem(imem_addr);

  if_fetch_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .if_id_pc4   (if_id_pc4),
    .if_id_instr (if_id_instr),
    .if_id_valid (if_id_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [96:0] e;
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0;
    tick(); tick();
    e = {32'h0, 32'h0, c_nop, 1'b0};
    checks++;
    if ({imem_addr, if_id_pc4, if_id_instr, if_id_valid} !== e) begin
      failures++;
      $display("FAIL reset: got addr=%h pc4=%h instr=%h v=%b want %h", imem_addr, if_id_pc4, if_id_instr, if_id_valid, e);
    end
  endtask

  task automatic test_seq_fetch();
    logic [96:0] e;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      e = {32'(4*(i+1)), 32'(4*(i+1)), mem(32'(4*i)), 1'b1};
      checks++;
      if ({imem_addr, if_id_pc4, if_id_instr, if_id_valid} !== e) begin
        failures++;
        $display("FAIL seq_fetch[%0d]: got addr=%h pc4=%h instr=%h v=%b want %h", i, imem_addr, if_id_pc4, if_id_instr, if_id_valid, e);
      end
    end
  endtask

  task automatic test_redirect();
    logic [96:0] e [2];
    e[0] = {32'h100, 32'h14, c_nop, 1'b0};
    e[1] = {32'h104, 32'h104, mem(32'h100), 1'b1};
    for (int i = 0; i < 2; i++) begin
      redirect = (i == 0); redirect_pc = 32'h103;
      tick();
      checks++;
      if ({imem_addr, if_id_pc4, if_id_instr, if_id_valid} !== e[i]) begin
        failures++;
        $display("FAIL redirect[%0d]: got addr=%h pc4=%h instr=%h v=%b want %h", i, imem_addr, if_id_pc4, if_id_instr, if_id_valid, e[i]);
      end
    end
    redirect = 1'b0;
  endtask

  task automatic test_stall();
    logic [96:0] e;
    redirect = 1'b1; redirect_pc = 32'h1C;
    tick();
    redirect = 1'b0;
    tick();
    e = {32'h20, 32'h20, mem(32'h1C), 1'b1};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({imem_addr, if_id_pc4, if_id_instr, if_id_valid} !== e) begin
        failures++;
        $display("FAIL stall_hold[%0d]: got addr=%h pc4=%h instr=%h v=%b want %h", i, imem_addr, if_id_pc4, if_id_instr, if_id_valid, e);
      end
      stall = (i < 3);
      if (i < 3) tick();
    end
    tick();
    e = {32'h24, 32'h24, mem(32'h20), 1'b1};
    checks++;
    if ({imem_addr, if_id_pc4, if_id_instr, if_id_valid} !== e) begin
      failures++;
      $display("FAIL stall_resume: got addr=%h pc4=%h instr=%h v=%b want %h", imem_addr, if_id_pc4, if_id_instr, if_id_valid, e);
    end
  endtask

  task automatic test_stall_redirect();
    logic [96:0] e [4];
    e[0] = {32'h24, 32'h24, mem(32'h20), 1'b1};
    e[1] = e[0];
    e[2] = {32'h200, 32'h28, c_nop, 1'b0};
    e[3] = {32'h204, 32'h204, mem(32'h200), 1'b1};
    redirect_pc = 32'h200;
    for (int i = 0; i < 4; i++) begin
      stall = (i < 2);
      redirect = (i < 3);
      tick();
      checks++;
      if ({imem_addr, if_id_pc4, if_id_instr, if_id_valid} !== e[i]) begin
        failures++;
        $display("FAIL stall_redirect[%0d]: got addr=%h pc4=%h instr=%h v=%b want %h", i, imem_addr, if_id_pc4, if_id_instr, if_id_valid, e[i]);
      end
    end
    stall = 1'b0; redirect = 1'b0;
  endtask

  task automatic test_wrap_reset();
    logic [96:0] e [4];
    e[0] = {32'hFFFF_FFFC, 32'h208, c_nop, 1'b0};
    e[1] = {32'h0, 32'h0, mem(32'hFFFF_FFFC), 1'b1};
    e[2] = {32'h4, 32'h4, mem(32'h0), 1'b1};
    e[3] = {32'h0, 32'h0, c_nop, 1'b0};
    for (int i = 0; i < 4; i++) begin
      redirect    = (i == 0) || (i == 3);
      redirect_pc = (i == 0) ? 32'hFFFF_FFFE : 32'h300;
      rst_n       = (i != 3);
      tick();
      checks++;
      if ({imem_addr, if_id_pc4, if_id_instr, if_id_valid} !== e[i]) begin
        failures++;
        $display("FAIL wrap_reset[%0d]: got addr=%h pc4=%h instr=%h v=%b want %h", i, imem_addr, if_id_pc4, if_id_instr, if_id_valid, e[i]);
      end
    end
    redirect = 1'b0; rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [96:0] e [3];
    logic [31:0] tgt [3];
    e[0] = {32'h400, 32'h4, c_nop, 1'b0};
    e[1] = {32'h500, 32'h404, c_nop, 1'b0};
    e[2] = {32'h504, 32'h504, mem(32'h500), 1'b1};
    tgt[0] = 32'h400; tgt[1] = 32'h500; tgt[2] = 32'h0;
    for (int i = 0; i < 3; i++) begin
      redirect = (i < 2); redirect_pc = tgt[i];
      tick();
      checks++;
      if ({imem_addr, if_id_pc4, if_id_instr, if_id_valid} !== e[i]) begin
        failures++;
        $display("FAIL back_to_back[%0d]: got addr=%h pc4=%h instr=%h v=%b want %h", i, imem_addr, if_id_pc4, if_id_instr, if_id_valid, e[i]);
      end
    end
    redirect = 1'b0;
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf_cnt();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({stall_cnt, flush_cnt} !== 64'h0) begin
      failures++;
      $display("FAIL perf_reset: got stall_cnt=%0d flush_cnt=%0d want 0 0", stall_cnt, flush_cnt);
    end
    rst_n = 1'b1;
    stall = 1'b1;
    repeat (3) tick();
    stall = 1'b0; redirect = 1'b1; redirect_pc = 32'h40;
    repeat (2) tick();
    redirect = 1'b0;
    tick();
    checks++;
    if ({stall_cnt, flush_cnt} !== {32'd3, 32'd2}) begin
      failures++;
      $display("FAIL perf_count: got stall_cnt=%0d flush_cnt=%0d want 3 2", stall_cnt, flush_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_seq_fetch();
    test_redirect();
    test_stall();
    test_stall_redirect();
    test_wrap_reset();
    test_back_to_back();
`ifdef FETCH_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
